// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-port register file.
//
// Purpose
//   NREGS x WIDTH register array with NRD combinational read ports, one
//   write port, optional write-to-read bypass, a hardwired-zero register,
//   a flag register that tracks flag_in, a sideband tap export and a clear
//   engine that zeroes the array one register per cycle.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   rs / rd        packed read indices / read data, port i at [i*AW +: AW] /
//                  [i*WIDTH +: WIDTH]
//   we, wa, wd     write enable, index, data
//   flag_in        hardware flag, loaded into FLAG_REG every cycle unless
//                  software writes it
//   clr_req        start a clear sweep (level, only looked at in IDLE)
//   clr_busy       sweep in progress (equal to wr_stall)
//   clr_done       one-cycle pulse after the last register is cleared
//   wr_stall       writes are currently being dropped by the sweep
//   tap_out        low TAP_W bits of TAP_REG
//   flag_out       bit 0 of FLAG_REG
//   state_dbg      clear-engine FSM state (0 IDLE, 1 CLEAR, 2 DONE)
//
// Handshake: there is no valid/ready pair here. A write is taken when
// we=1 in IDLE with wa != ZERO_REG; every other write is dropped without
// notice. wr_stall tells the writer that the drop is due to a sweep.
module regfile_param #(
  parameter int NREGS    = 16,
  parameter int WIDTH    = 32,
  parameter int NRD      = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 15,
  parameter int FLAG_REG = 13,
  parameter int TAP_REG  = 6,
  parameter int TAP_W    = 11,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rs,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 flag_in,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 wr_stall,
  output logic [TAP_W-1:0]     tap_out,
  output logic                 flag_out,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             wr_acc;
  logic             clearing;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_val;

  // A ZERO_REG at or beyond NREGS never matches, which disables the feature.
  assign wr_acc   = we && (state_q == IDLE) && !rst && (int'(wa) != ZERO_REG);
  assign clearing = (state_q == CLEAR);

  // Clear-engine FSM: next state and sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(NREGS - 1)) state_d = DONE;
      end
      DONE: begin
        // clr_req is deliberately not looked at here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array next value. Priority inside one cycle: sweep slot or software
  // write (never both, writes are only taken in IDLE) over the flag_in reload.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (i == FLAG_REG) regs_d[i] = {{(WIDTH-1){1'b0}}, flag_in};
    end
    if (clearing) regs_d[ptr_q] = '0;
    if (wr_acc)   regs_d[wa]    = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational read ports. The zero override is applied last so it
  // also beats the bypass path.
  always_comb begin
    rd     = '0;
    rd_idx = '0;
    rd_val = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_idx = rs[i*AW +: AW];
      rd_val = regs_q[rd_idx];
      if ((BYPASS != 0) && wr_acc && (wa == rd_idx)) rd_val = wd;
      if (int'(rd_idx) == ZERO_REG) rd_val = '0;
      rd[i*WIDTH +: WIDTH] = rd_val;
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = (state_q == DONE);
  assign wr_stall  = clr_busy;
  assign tap_out   = regs_q[TAP_REG][TAP_W-1:0];
  assign flag_out  = regs_q[FLAG_REG][0];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench for regfile_param with default parameters
// (16 x 32, 3 read ports, bypass on, zero reg 15, flag reg 13, tap reg 6,
// 11-bit tap). Inputs change on the falling edge; outputs are sampled on a
// falling edge or 1 ns after an input change, well away from the rising edge.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic [11:0] rs;
  logic [95:0] rd;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        flag_in;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_stall;
  logic [10:0] tap_out;
  logic        flag_out;
  logic [1:0]  state_dbg;

  int n_vec;
  int n_bad;
  logic [31:0] exp_q[$];

  regfile_param dut (
    .clk       (clk),
    .rst       (rst),
    .rs        (rs),
    .rd        (rd),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .flag_in   (flag_in),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_stall  (wr_stall),
    .tap_out   (tap_out),
    .flag_out  (flag_out),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_rs(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
    rs = {a2, a1, a0};
  endtask

  // Leaves the bench on the falling edge after the write has been clocked.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_rs(4'd15, 4'd6, 4'd0);
    #1;
    n_vec++; if (rd[31:0]  !== 32'h0) begin n_bad++; $display("FAIL reset_rd0: got %h want %h", rd[31:0], 32'h0); end
    n_vec++; if (rd[63:32] !== 32'h0) begin n_bad++; $display("FAIL reset_rd1: got %h want %h", rd[63:32], 32'h0); end
    n_vec++; if (rd[95:64] !== 32'h0) begin n_bad++; $display("FAIL reset_rd2: got %h want %h", rd[95:64], 32'h0); end
    n_vec++; if (tap_out !== 11'h0) begin n_bad++; $display("FAIL reset_tap: got %h want %h", tap_out, 11'h0); end
    n_vec++; if (flag_out !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want %b", flag_out, 1'b0); end
    n_vec++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want %b", clr_busy, 1'b0); end
    n_vec++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want %b", clr_done, 1'b0); end
    n_vec++; if (state_dbg !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, 0); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp;
    @(negedge clk);
    we = 1'b1; wa = 4'd6; wd = 32'h0000_0ABC;
    set_rs(4'd0, 4'd6, 4'd0);
    #1;
    n_vec++; if (rd[63:32] !== 32'h0000_0ABC) begin n_bad++; $display("FAIL bypass_rd1: got %h want %h", rd[63:32], 32'h0000_0ABC); end
    n_vec++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL bypass_other_rd0: got %h want %h", rd[31:0], 32'h0); end
    @(negedge clk);
    we = 1'b0;
    set_rs(4'd0, 4'd0, 4'd6);
    #1;
    n_vec++; if (rd[31:0] !== 32'h0000_0ABC) begin n_bad++; $display("FAIL stored_rd0: got %h want %h", rd[31:0], 32'h0000_0ABC); end
    n_vec++; if (tap_out !== 11'h2BC) begin n_bad++; $display("FAIL tap_trunc: got %h want %h", tap_out, 11'h2BC); end
    // All three ports on the same index.
    set_rs(4'd6, 4'd6, 4'd6);
    for (int p = 0; p < 3; p++) exp_q.push_back(32'h0000_0ABC);
    #1;
    for (int p = 0; p < 3; p++) begin
      exp = exp_q.pop_front();
      n_vec++;
      if (rd[p*32 +: 32] !== exp) begin n_bad++; $display("FAIL same_idx_rd%0d: got %h want %h", p, rd[p*32 +: 32], exp); end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we = 1'b1; wa = 4'd15; wd = 32'hFFFF_FFFF;
    set_rs(4'd15, 4'd15, 4'd15);
    #1;
    n_vec++; if (rd !== 96'h0) begin n_bad++; $display("FAIL zero_bypass: got %h want %h", rd, 96'h0); end
    @(negedge clk);
    we = 1'b0;
    #1;
    n_vec++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL zero_stored: got %h want %h", rd[31:0], 32'h0); end
  endtask

  task automatic test_flag();
    @(negedge clk);
    flag_in = 1'b1;
    set_rs(4'd0, 4'd0, 4'd13);
    @(negedge clk);
    n_vec++; if (flag_out !== 1'b1) begin n_bad++; $display("FAIL flag_follow: got %b want %b", flag_out, 1'b1); end
    n_vec++; if (rd[31:0] !== 32'h1) begin n_bad++; $display("FAIL flag_rd: got %h want %h", rd[31:0], 32'h1); end
    we = 1'b1; wa = 4'd13; wd = 32'h5; flag_in = 1'b0;
    @(negedge clk);
    we = 1'b0;
    #1;
    n_vec++; if (rd[31:0] !== 32'h5) begin n_bad++; $display("FAIL flag_sw_wins: got %h want %h", rd[31:0], 32'h5); end
    n_vec++; if (flag_out !== 1'b1) begin n_bad++; $display("FAIL flag_sw_bit0: got %b want %b", flag_out, 1'b1); end
    @(negedge clk);
    n_vec++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL flag_reload: got %h want %h", rd[31:0], 32'h0); end
    n_vec++; if (flag_out !== 1'b0) begin n_bad++; $display("FAIL flag_out_low: got %b want %b", flag_out, 1'b0); end
  endtask

  task automatic test_clear_sweep();
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    do_write(4'd1, 32'h7);
    do_write(4'd9, 32'h9);
    do_write(4'd6, 32'h0000_0ABC);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    // k counts falling edges after the request was sampled; CLEAR covers k=1..16.
    for (int k = 1; k <= 24; k++) begin
      if (k == 4) begin
        we = 1'b1; wa = 4'd2; wd = 32'h3;
        set_rs(4'd0, 4'd0, 4'd2);
        #1;
        n_vec++; if (wr_stall !== 1'b1) begin n_bad++; $display("FAIL sweep_stall: got %b want %b", wr_stall, 1'b1); end
        n_vec++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL sweep_no_bypass: got %h want %h", rd[31:0], 32'h0); end
      end
      if (k == 5) begin
        we = 1'b0;
        set_rs(4'd2, 4'd9, 4'd1);
        #1;
        n_vec++; if (rd[31:0] !== 32'h0) begin n_bad++; $display("FAIL mid_swept_r1: got %h want %h", rd[31:0], 32'h0); end
        n_vec++; if (rd[63:32] !== 32'h9) begin n_bad++; $display("FAIL mid_unswept_r9: got %h want %h", rd[63:32], 32'h9); end
        n_vec++; if (rd[95:64] !== 32'h0) begin n_bad++; $display("FAIL sweep_drop_r2: got %h want %h", rd[95:64], 32'h0); end
      end
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_at = k; end
      @(negedge clk);
    end
    n_vec++; if (busy_cnt !== 16) begin n_bad++; $display("FAIL sweep_busy_len: got %0d want %0d", busy_cnt, 16); end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL sweep_done_cnt: got %0d want %0d", done_cnt, 1); end
    n_vec++; if (done_at !== 17) begin n_bad++; $display("FAIL sweep_done_at: got %0d want %0d", done_at, 17); end
    set_rs(4'd6, 4'd9, 4'd2);
    #1;
    n_vec++; if (rd !== 96'h0) begin n_bad++; $display("FAIL sweep_all_zero: got %h want %h", rd, 96'h0); end
    n_vec++; if (tap_out !== 11'h0) begin n_bad++; $display("FAIL sweep_tap_zero: got %h want %h", tap_out, 11'h0); end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    do_write(4'd5, 32'h55);
    do_write(4'd14, 32'hEE);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_rs(4'd3, 4'd14, 4'd5);
    #1;
    n_vec++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want %b", clr_busy, 1'b0); end
    n_vec++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want %b", clr_done, 1'b0); end
    n_vec++; if (rd !== 96'h0) begin n_bad++; $display("FAIL rstmid_regs: got %h want %h", rd, 96'h0); end
    we = 1'b1; wa = 4'd3; wd = 32'h33;
    #1;
    n_vec++; if (rd[95:64] !== 32'h33) begin n_bad++; $display("FAIL rstmid_wr_bypass: got %h want %h", rd[95:64], 32'h33); end
    @(negedge clk);
    we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_vec++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_busy: got %0d want %0d", busy_cnt, 0); end
    n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, 0); end
    n_vec++; if (rd[95:64] !== 32'h33) begin n_bad++; $display("FAIL rstmid_wr_stored: got %h want %h", rd[95:64], 32'h33); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    rs      = '0;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    flag_in = 1'b0;
    clr_req = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_flag();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
